sdiv8r4: RTL



---
 rtl/sdiv_pkg.sv | 32 +++
 rtl/sdiv_r4_step.sv | 37 +++
 rtl/sdiv8r4.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_pkg
// Description : Shared widths, constants, state encoding and helpers for the
//               sdiv8r4 signed radix-4 divider.
// Revision    : 1.0 - initial release
// ============================================================================
package sdiv_pkg;

    localparam int DW          = 8;   // operand width
    localparam int PRW         = 10;  // partial remainder width
    localparam int CALC_CYCLES = 4;   // radix-4 digits per operation
    localparam int LAT         = 5;   // accept-to-result latency, normal path
    localparam int CNT_W       = 2;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CALC_CYCLES - 1);
    localparam logic [DW-1:0]    DBZ_Q    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's-complement value; -128 maps to 128 (8'h80 unsigned).
    function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdiv_r4_step.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_r4_step
// Description : One radix-4 restoring-division digit. Picks the largest of
//               3|y|, 2|y|, |y| that fits in the shifted partial remainder,
//               subtracts it and reports the selected digit.
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv_r4_step
    import sdiv_pkg::*;
(
    input  logic [PRW-1:0] i_pr_sh,
    input  logic [PRW-1:0] i_m1,
    input  logic [PRW-1:0] i_m2,
    input  logic [PRW-1:0] i_m3,
    output logic [1:0]     o_digit,
    output logic [PRW-1:0] o_pr_nxt
);

    // Digit selection: largest multiple not exceeding the partial remainder
    always_comb begin
        o_digit  = 2'd0;
        o_pr_nxt = i_pr_sh;
        if (i_pr_sh >= i_m3) begin
            o_digit  = 2'd3;
            o_pr_nxt = i_pr_sh - i_m3;
        end else if (i_pr_sh >= i_m2) begin
            o_digit  = 2'd2;
            o_pr_nxt = i_pr_sh - i_m2;
        end else if (i_pr_sh >= i_m1) begin
            o_digit  = 2'd1;
            o_pr_nxt = i_pr_sh - i_m1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdiv8r4.sv
`default_nettype none
// ============================================================================
// Module      : sdiv8r4
// Description : Sequential 8-bit signed radix-4 divider with valid/ready
//               handshakes. Truncating quotient, remainder signed like the
//               dividend. Optional macro SDIV_REM_EN enables the remainder
//               output; without it r is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv8r4
    import sdiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] q,
    output logic [DW-1:0] r,
    output logic          dbz,
    output logic          ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_dvd;      // |x|, consumed two bits per CALC cycle
    logic [PRW-1:0]   r_pr;
    logic [PRW-1:0]   r_m1;
    logic [PRW-1:0]   r_m2;
    logic [PRW-1:0]   r_m3;
    logic [DW-1:0]    r_qmag;
    logic             r_sq;
    logic             r_ovf_pend;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DW-1:0]    r_q;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_y_zero;
    logic [DW-1:0]    w_ax;
    logic [DW-1:0]    w_ay;
    logic [PRW-1:0]   w_pr_sh;
    logic [1:0]       w_digit;
    logic [PRW-1:0]   w_pr_nxt;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_y_zero = (y == '0);
    assign w_ax     = abs_u(x);
    assign w_ay     = abs_u(y);
    assign w_pr_sh  = (r_pr << 2) | {{(PRW-2){1'b0}}, r_dvd[DW-1 -: 2]};

    sdiv_r4_step u_step (
        .i_pr_sh  (w_pr_sh),
        .i_m1     (r_m1),
        .i_m2     (r_m2),
        .i_m3     (r_m3),
        .o_digit  (w_digit),
        .o_pr_nxt (w_pr_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; divide-by-zero passes through FIX so its result
    // appears one cycle after accept, same as the handshake timing expects
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_nxt = w_y_zero ? FIX : CALC;
            CALC: if (r_cnt == '0) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Iteration datapath: operand capture on accept, one digit per CALC cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dvd      <= w_ax;
            r_m1       <= {2'b00, w_ay};
            r_m2       <= {1'b0, w_ay, 1'b0};
            r_m3       <= {2'b00, w_ay} + {1'b0, w_ay, 1'b0};
            r_pr       <= '0;
            r_qmag     <= '0;
            r_cnt      <= CNT_INIT;
            r_sq       <= x[DW-1] ^ y[DW-1];
            r_ovf_pend <= (x == 8'h80) && (y == 8'hFF);
        end else if (r_state == CALC) begin
            r_pr   <= w_pr_nxt;
            r_qmag <= {r_qmag[DW-3:0], w_digit};
            r_dvd  <= {r_dvd[DW-3:0], 2'b00};
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // Handshake and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_dbz      <= w_y_zero;
                        r_ovf      <= 1'b0;
                        if (w_y_zero) r_q <= DBZ_Q;
                    end
                end
                FIX: begin
                    r_out_valid <= 1'b1;
                    if (!r_dbz) begin
                        r_q   <= r_sq ? (~r_qmag + 1'b1) : r_qmag;
                        r_ovf <= r_ovf_pend;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDIV_REM_EN
    logic          r_sx;
    logic [DW-1:0] r_rem;
    logic [DW-1:0] w_rmag;

    assign w_rmag = r_pr[DW-1:0];

    // Remainder: dividend on divide-by-zero, sign of x applied in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_sx  <= 1'b0;
        end else if (w_accept) begin
            r_sx <= x[DW-1];
            if (w_y_zero) r_rem <= x;
        end else if ((r_state == FIX) && !r_dbz) begin
            r_rem <= r_sx ? (~w_rmag + 1'b1) : w_rmag;
        end
    end

    assign r = r_rem;
`else
    assign r = '0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
